// File: rtl/systolic_result_drain_pkg.sv
// Shared types for the systolic result drain: FSM state encoding and output-buffer sizing.
package systolic_result_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/systolic_result_drain_fifo.sv
// Small synchronous show-ahead FIFO: the head word is visible on o_head whenever o_empty is low.
module systolic_result_drain_fifo
    import systolic_result_drain_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enq_val,
    input  logic [WIDTH-1:0] i_enq_data,
    output logic             o_full,
    input  logic             i_deq,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_wr    = i_enq_val && !o_full;
    assign w_rd    = i_deq && !o_empty;
    assign o_head  = r_mem[r_rptr];

    // NOTE: storage is deliberately not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Drains all SIZE*SIZE PE sums of a systolic array in row-major order onto a valid/ready stream.
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int NBITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(SIZE)-1:0] out_rsel,
    output logic [$clog2(SIZE)-1:0] out_csel,
    input  logic [NBITS-1:0]        b_s_out,
    output logic [NBITS-1:0]        resp_msg,
    output logic                    resp_last,
    output logic                    resp_val,
    input  logic                    resp_rdy
);

    localparam int SW = $clog2(SIZE);

    drain_state_e     r_state;
    logic [SW-1:0]    r_row;
    logic [SW-1:0]    r_col;
    logic             r_done;

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;
    logic             w_last_idx;
    logic [NBITS:0]   w_head;

    // SIZE is a power of two, so the final row/column index is all ones.
    assign w_last_idx = (&r_row) && (&r_col);
    assign w_enq      = (r_state == FETCH) && !w_full;
    assign w_deq      = resp_val && resp_rdy;

    assign out_rsel   = r_row;
    assign out_csel   = r_col;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign resp_val   = !w_empty;
    assign resp_msg   = w_head[NBITS-1:0];
    assign resp_last  = w_head[NBITS];

    systolic_result_drain_fifo #(
        .WIDTH (NBITS + 1),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .i_enq_val  (w_enq),
        .i_enq_data ({w_last_idx, b_s_out}),
        .o_full     (w_full),
        .i_deq      (w_deq),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    // Selects freeze while the buffer is full so no PE sum is skipped.
                    if (w_enq) begin
                        if (w_last_idx) begin
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= FLUSH;
                        end else if (&r_col) begin
                            r_col <= '0;
                            r_row <= r_row + SW'(1);
                        end else begin
                            r_col <= r_col + SW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (w_deq && resp_last) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: scoreboard on the result stream plus cycle-exact vectors.
module tb_systolic_result_drain;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  out_rsel;
    logic [1:0]  out_csel;
    logic [15:0] b_s_out;
    logic [15:0] resp_msg;
    logic        resp_last;
    logic        resp_val;
    logic        resp_rdy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_xfer = 0;
    int n_done = 0;
    int first_val_cyc  = -1;
    int first_xfer_cyc = -1;
    int last_xfer_cyc  = -1;

    logic [16:0] sb [$];
    logic        prev_stall = 1'b0;
    logic [16:0] prev_word  = '0;

    typedef struct {
        logic        rdy;
        logic        val;
        logic [1:0]  rsel;
        logic [1:0]  csel;
        logic [15:0] msg;
    } vec_t;

    vec_t tbl [8];

    systolic_result_drain #(
        .SIZE  (4),
        .NBITS (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_rsel  (out_rsel),
        .out_csel  (out_csel),
        .b_s_out   (b_s_out),
        .resp_msg  (resp_msg),
        .resp_last (resp_last),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy)
    );

    // PE(i,j) model: each PE holds 16*i + j.
    always_comb b_s_out = {10'd0, out_rsel, 4'd0} + {14'd0, out_csel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_drain();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                sb.push_back({(i == 3 && j == 3) ? 1'b1 : 1'b0, 16'(16 * i + j)});
            end
        end
    endtask

    // Drives a one-cycle start pulse; returns the cycle index in which start was high.
    task automatic start_drain(output int s);
        @(posedge clk);
        #1;
        start = 1'b1;
        push_drain();
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns positioned #1 after the edge that raised done, i.e. inside the done cycle.
    task automatic wait_done(input int budget, output int dcyc);
        bit got = 1'b0;
        dcyc = -1;
        for (int k = 0; k < budget && !got; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got  = 1'b1;
                dcyc = cyc;
            end
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stream monitor: samples mid-cycle, when inputs and outputs are both settled.
    always @(negedge clk) begin
        if (resp_val === 1'b1 && first_val_cyc < 0) first_val_cyc = cyc;
        if (done === 1'b1) n_done++;
        if (prev_stall && !rst) begin
            check("hold_stable", {14'd0, resp_val, resp_last, resp_msg}, {14'd0, 1'b1, prev_word});
        end
        if (resp_val === 1'b1 && resp_rdy === 1'b1) begin
            n_xfer++;
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_word got=%0h (cycle %0d)", {resp_last, resp_msg}, cyc);
            end else begin
                check("word", {15'd0, resp_last, resp_msg}, {15'd0, sb.pop_front()});
            end
        end
        prev_stall = (resp_val === 1'b1) && (resp_rdy === 1'b0) && !rst;
        prev_word  = {resp_last, resp_msg};
    end

    initial begin
        #400000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        int s;
        int s2;
        int dcyc;
        int x0;
        int d0;

        // cycle-relative vectors for the backpressure case, starting one cycle after start
        tbl[0] = '{1'b0, 1'b0, 2'd0, 2'd0, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 2'd0, 2'd1, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 2'd0, 2'd2, 16'd0};
        tbl[3] = '{1'b0, 1'b1, 2'd0, 2'd2, 16'd0};
        tbl[4] = '{1'b0, 1'b1, 2'd0, 2'd2, 16'd0};
        tbl[5] = '{1'b1, 1'b1, 2'd0, 2'd2, 16'd0};
        tbl[6] = '{1'b1, 1'b1, 2'd0, 2'd2, 16'd1};
        tbl[7] = '{1'b1, 1'b1, 2'd0, 2'd3, 16'd2};

        rst      = 1'b1;
        start    = 1'b0;
        resp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_val",  32'(resp_val), 32'd0);
        check("rst_rsel", 32'(out_rsel), 32'd0);
        check("rst_csel", 32'(out_csel), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        // Full-rate drain.
        first_val_cyc  = -1;
        first_xfer_cyc = -1;
        x0 = n_xfer;
        d0 = n_done;
        start_drain(s);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(60, dcyc);
        check("first_val_latency", 32'(first_val_cyc - s), 32'd2);
        check("done_latency", 32'(dcyc - s), 32'd18);
        check("consecutive_words", 32'(last_xfer_cyc - first_xfer_cyc), 32'd15);
        idle_cycles(3);
        check("a_word_count", 32'(n_xfer - x0), 32'd16);
        check("a_done_count", 32'(n_done - d0), 32'd1);
        check("a_idle", 32'(busy), 32'd0);
        check("a_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: consumer stalls through the start cycle and the five after it.
        resp_rdy = 1'b0;
        x0 = n_xfer;
        start_drain(s);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            resp_rdy = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("bp_val_%0d", i),  32'(resp_val), 32'(tbl[i].val));
            check($sformatf("bp_rsel_%0d", i), 32'(out_rsel), 32'(tbl[i].rsel));
            check($sformatf("bp_csel_%0d", i), 32'(out_csel), 32'(tbl[i].csel));
            check($sformatf("bp_busy_%0d", i), 32'(busy), 32'd1);
            if (tbl[i].val) check($sformatf("bp_msg_%0d", i), 32'(resp_msg), 32'(tbl[i].msg));
        end
        wait_done(60, dcyc);
        idle_cycles(3);
        check("b_word_count", 32'(n_xfer - x0), 32'd16);
        check("b_sb_empty", 32'(sb.size()), 32'd0);

        // Random consumer readiness.
        x0 = n_xfer;
        d0 = n_done;
        start_drain(s);
        begin
            bit got = 1'b0;
            for (int k = 0; k < 300 && !got; k++) begin
                resp_rdy = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                if (done) got = 1'b1;
            end
            check("c_done_seen", 32'(got), 32'd1);
        end
        resp_rdy = 1'b1;
        idle_cycles(4);
        check("c_word_count", 32'(n_xfer - x0), 32'd16);
        check("c_done_count", 32'(n_done - d0), 32'd1);
        check("c_sb_empty", 32'(sb.size()), 32'd0);

        // Start pulses during FETCH (cycle +5) and FLUSH (cycle +17) must be ignored.
        x0 = n_xfer;
        d0 = n_done;
        start_drain(s);
        for (int k = 2; k <= 24; k++) begin
            @(posedge clk);
            #1;
            start = (k == 5 || k == 17);
        end
        start = 1'b0;
        idle_cycles(2);
        check("d_word_count", 32'(n_xfer - x0), 32'd16);
        check("d_done_count", 32'(n_done - d0), 32'd1);
        check("d_idle", 32'(busy), 32'd0);
        check("d_sb_empty", 32'(sb.size()), 32'd0);

        // Reset asserted in the cycle of the 7th transfer aborts the drain.
        x0 = n_xfer;
        start_drain(s);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("e_busy", 32'(busy), 32'd0);
        check("e_done", 32'(done), 32'd0);
        check("e_val",  32'(resp_val), 32'd0);
        check("e_rsel", 32'(out_rsel), 32'd0);
        check("e_csel", 32'(out_csel), 32'd0);
        check("e_xfers_before_rst", 32'(n_xfer - x0), 32'd7);
        x0 = n_xfer;
        start_drain(s);
        wait_done(60, dcyc);
        check("e_restart_latency", 32'(dcyc - s), 32'd18);
        idle_cycles(2);
        check("e_restart_words", 32'(n_xfer - x0), 32'd16);
        check("e_sb_empty", 32'(sb.size()), 32'd0);

        // Start in the done cycle launches a second drain back-to-back.
        x0 = n_xfer;
        d0 = n_done;
        start_drain(s);
        wait_done(60, dcyc);
        start = 1'b1;
        push_drain();
        s2 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("f_busy_second", 32'(busy), 32'd1);
        wait_done(60, dcyc);
        check("f_second_latency", 32'(dcyc - s2), 32'd18);
        idle_cycles(3);
        check("f_word_count", 32'(n_xfer - x0), 32'd32);
        check("f_done_count", 32'(n_done - d0), 32'd2);
        check("f_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 SHALL have parameter SIZE, default 4: array dimension; power of two, at least 2.
REQ-002 SHALL have parameter NBITS, default 16: result word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to drain all SIZE*SIZE results.
REQ-006 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse after the final result handshake.
REQ-008 SHALL have port out_rsel, output, $clog2(SIZE) bits: row select driven to the systolic datapath.
REQ-009 SHALL have port out_csel, output, $clog2(SIZE) bits: column select driven to the systolic datapath.
REQ-010 SHALL have port b_s_out, input, NBITS bits: selected PE sum, combinational from the selects.
REQ-011 SHALL have port resp_msg, output, NBITS bits: streamed result word.
REQ-012 SHALL have port resp_last, output, 1 bit: marks the word from PE (SIZE-1, SIZE-1).
REQ-013 SHALL have port resp_val, output, 1 bit: resp_msg and resp_last are valid.
REQ-014 SHALL have port resp_rdy, input, 1 bit: consumer accepts; a transfer occurs when resp_val and resp_rdy are both high.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, FLUSH.
REQ-016 SHALL go IDLE->FETCH on start; start SHALL be ignored in FETCH and FLUSH.
REQ-017 SHALL drive out_rsel/out_csel directly from registered row/col counters, which are 0 in IDLE.
REQ-018 SHALL, in FETCH when the output buffer is not full, write {last, b_s_out} into the buffer and advance the counters in row-major order (col first).
REQ-019 SHALL hold counters and selects while the buffer is full.
REQ-020 SHALL, on writing index SIZE*SIZE-1, set last=1, wrap the counters to 0, and go FETCH->FLUSH.
REQ-021 SHALL, in FLUSH, go to IDLE on the transfer with resp_last=1 and assert done in the following cycle.
REQ-022 SHALL drive resp_val = buffer not empty and resp_msg/resp_last = buffer head (show-ahead), and dequeue on each transfer.
REQ-023 SHALL keep resp_msg/resp_last stable while resp_val=1 and resp_rdy=0.
REQ-024 SHALL sustain 1 word/cycle with resp_rdy held high: first resp_val 2 cycles after start is sampled, done 18 cycles after start for SIZE=4.
REQ-025 SHALL accept start in the same cycle done is high, since the state is already IDLE.
REQ-026 SHALL pass results unmodified with no width change; the caller SHALL hold mac_en low during a drain.

Reset
REQ-027 SHALL, when rst is sampled high, set state IDLE, counters 0, buffer empty, and busy=0, done=0, resp_val=0, out_rsel=0, out_csel=0.
REQ-028 SHALL abort any drain mid-operation on rst and discard buffered words.

Structure
REQ-029 SHALL place the FSM state enum in the shared systolic package; SIZE and NBITS remain module parameters.
REQ-030 SHALL use the existing SyncFIFO (depth 2, width NBITS+1, show-ahead) as the single sub-module output buffer.

Verification
REQ-031 SHALL verify: SIZE=4, PE(i,j) model returns 16*i+j, resp_rdy=1, start pulse -> words 0,1,2,3,16,...,51 on consecutive cycles, resp_last only on 51, done 18 cycles after start.
REQ-032 SHALL verify: resp_rdy=0 for 5 cycles after start -> 2 words buffered, selects frozen at (0,2), head 0 stable; release -> no loss or duplication.
REQ-033 SHALL verify: random resp_rdy at 50% -> all 16 words in order, exactly one done pulse.
REQ-034 SHALL verify: start pulsed in FETCH and FLUSH -> ignored, exactly 16 words.
REQ-035 SHALL verify: rst at the 7th transfer -> all outputs at reset values next cycle; new start -> full sequence from 0.
REQ-036 SHALL verify: start asserted in the done cycle -> second full drain back-to-back.
